conv_core_kxk: RTL and testbench

//   Parametrised KxK single-precision convolution core: one window of K*K pixels per accepted beat.

---
 rtl/conv_core_kxk.sv | 219 +++++++++++++++++++++
 tb/tb_conv_core_kxk.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_core_kxk.sv
// rtl/conv_core_kxk.sv - KxK single-precision convolution core with pipelined adder tree

// Combinational single-precision multiply, round-nearest-even.
// Subnormal operands are read as zero and subnormal results flush to signed zero.
module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              sign;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       prod;
  logic [22:0]       mant;
  logic              guard, sticky;
  logic [23:0]       rnd;
  logic signed [9:0] exp_r;

  assign sign   = a[31] ^ b[31];
  assign a_zero = (a[30:23] == 8'd0);
  assign b_zero = (b[30:23] == 8'd0);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};

  // Normalise the 48-bit product, round to nearest even, then resolve special operands
  always_comb begin
    exp_r = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_r  = exp_r + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    if (rnd[23]) exp_r = exp_r + 10'sd1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y = 32'h7FC00000;
    else if (a_inf || b_inf)                                      y = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                    y = {sign, 31'd0};
    else if (exp_r >= 10'sd255)                                   y = {sign, 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0)                                     y = {sign, 31'd0};
    else                                                          y = {sign, exp_r[7:0], rnd[22:0]};
  end
endmodule

// Combinational single-precision add, round-nearest-even, same subnormal handling as fp_mul.
module fp_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [31:0] x, z;
  logic [7:0]  dexp;
  logic [50:0] ax, az, s, nrm;
  logic [23:0] rnd;
  int          pos;
  int          e;

  assign a_zero = (a[30:23] == 8'd0);
  assign b_zero = (b[30:23] == 8'd0);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  // Align the smaller operand, add or subtract, renormalise and round.
  // 26 guard bits keep alignments up to 26 exact; beyond that the smaller
  // operand only matters as a sticky bit, so it collapses to the LSB.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      x = a;
      z = b;
    end else begin
      x = b;
      z = a;
    end
    dexp = x[30:23] - z[30:23];
    ax   = {2'b01, x[22:0], 26'd0};
    az   = (dexp > 8'd26) ? 51'd1 : ({2'b01, z[22:0], 26'd0} >> dexp);
    s    = (x[31] == z[31]) ? (ax + az) : (ax - az);
    pos  = 0;
    for (int i = 0; i < 51; i++) begin
      if (s[i]) pos = i;
    end
    nrm = s << (50 - pos);
    e   = {24'd0, x[30:23]};
    e   = e + pos - 49;
    rnd = {1'b0, nrm[49:27]} + {23'd0, nrm[26] & ((|nrm[25:0]) | nrm[27])};
    if (rnd[23]) e = e + 1;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = 32'h7FC00000;
    else if (a_inf)            y = a;
    else if (b_inf)            y = b;
    else if (a_zero && b_zero) y = {a[31] & b[31], 31'd0};
    else if (a_zero)           y = b;
    else if (b_zero)           y = a;
    else if (s == 51'd0)       y = 32'd0;
    else if (e >= 255)         y = {x[31], 8'hFF, 23'd0};
    else if (e <= 0)           y = {x[31], 31'd0};
    else                       y = {x[31], e[7:0], rnd[22:0]};
  end
endmodule

module conv_core_kxk #(
  parameter int K  = 3,
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wt_we,
  input  logic [AW-1:0]   wt_addr,
  input  logic [DW-1:0]   wt_data,
  input  logic            relu_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [K*K*DW-1:0] pix_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [DW-1:0]   out_data
);
  localparam int N = K * K;
  localparam int D = $clog2(N);

  // Number of live operands at tree level s (level 0 = products)
  function automatic int cnt(input int s);
    return (N + (1 << s) - 1) >> s;
  endfunction

  logic          en;
  logic [DW-1:0] wt [N];
  logic [DW-1:0] bias;
  logic [DW-1:0] sum;

  // One global advance: the whole pipe moves unless the output is full and stalled
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Kernel/bias load port; addresses above N are silently dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N; t++) wt[t] <= '0;
      bias <= '0;
    end else if (wt_we) begin
      for (int t = 0; t < N; t++) begin
        if (wt_addr == AW'(t)) wt[t] <= wt_data;
      end
      if (wt_addr == AW'(N)) bias <= wt_data;
    end
  end

  for (genvar s = 0; s <= D; s++) begin : g_lvl
    localparam int C = cnt(s);
    logic          v, l, r;
    logic [DW-1:0] b;
    logic [DW-1:0] q  [C];
    logic          nv, nl, nr;
    logic [DW-1:0] nb;
    logic [DW-1:0] nq [C];

    if (s == 0) begin : g_p1
      // Bias is captured with the beat so later bias writes never touch it
      assign nv = in_valid & en;
      assign nl = in_last;
      assign nr = relu_en;
      assign nb = bias;
      for (genvar t = 0; t < N; t++) begin : g_mul
        fp_mul u_mul (.a(pix_i[t*DW +: DW]), .b(wt[t]), .y(nq[t]));
      end
    end else begin : g_tree
      localparam int PC = cnt(s - 1);
      assign nv = g_lvl[s-1].v;
      assign nl = g_lvl[s-1].l;
      assign nr = g_lvl[s-1].r;
      assign nb = g_lvl[s-1].b;
      for (genvar j = 0; j < C; j++) begin : g_pair
        if (2 * j + 1 < PC) begin : g_add
          fp_add u_add (.a(g_lvl[s-1].q[2*j]), .b(g_lvl[s-1].q[2*j+1]), .y(nq[j]));
        end else begin : g_pass
          assign nq[j] = g_lvl[s-1].q[2*j];
        end
      end
    end

    // Stage register: only the valid bit needs reset; bubbles shift like data
    always_ff @(posedge clk) begin
      if (rst)     v <= 1'b0;
      else if (en) v <= nv;
      if (en) begin
        q <= nq;
        l <= nl;
        r <= nr;
        b <= nb;
      end
    end
  end

  fp_add u_bias (.a(g_lvl[D].q[0]), .b(g_lvl[D].b), .y(sum));

  // Output register: add bias, clamp any negative-signed result when ReLU rides with the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= g_lvl[D].v;
      out_last  <= g_lvl[D].l;
      out_data  <= (g_lvl[D].r && sum[DW-1]) ? '0 : sum;
    end
  end
endmodule

// File: tb/tb_conv_core_kxk.sv
// tb/tb_conv_core_kxk.sv - directed self-checking bench for conv_core_kxk
module tb_conv_core_kxk;
  localparam int K  = 3;
  localparam int N  = K * K;
  localparam int DW = 32;
  localparam int AW = 6;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] M_ONE = 32'hBF800000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wt_we = 1'b0;
  logic [AW-1:0]   wt_addr = '0;
  logic [DW-1:0]   wt_data = '0;
  logic            relu_en = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [N*DW-1:0] pix_i = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic [DW-1:0]   out_data;

  int passed = 0;
  int total  = 0;

  conv_core_kxk #(.K(K), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .pix_i(pix_i), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Small positive integer to single precision
  function automatic logic [31:0] fp(input int n);
    int          p;
    logic [31:0] m;
    logic [7:0]  e8;
    p = 0;
    for (int i = 0; i < 31; i++) if (((n >> i) & 1) == 1) p = i;
    m  = 32'(n << (23 - p)) & 32'h007FFFFF;
    e8 = 8'(127 + p);
    return {1'b0, e8, m[22:0]};
  endfunction

  task automatic wr(input int addr, input logic [31:0] data);
    wt_we   = 1'b1;
    wt_addr = AW'(addr);
    wt_data = data;
    step();
    wt_we   = 1'b0;
  endtask

  task automatic load_all(input logic [31:0] w, input logic [31:0] bv);
    for (int t = 0; t < N; t++) wr(t, w);
    wr(N, bv);
  endtask

  task automatic set_pix(input logic [31:0] tap0);
    for (int t = 0; t < N; t++) pix_i[t*DW +: DW] = ONE;
    pix_i[0 +: DW] = tap0;
  endtask

  // Wait (bounded) for a result with out_ready=1, check it, consume it
  task automatic wait_out(input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_arrived"}, {31'd0, out_valid}, 32'd1);
    chk(tag, out_data, exp);
    chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
    step();
  endtask

  // Present one beat on an idle pipe and check it lands exactly six cycles later for one cycle
  task automatic lat6(input logic [31:0] exp, input string tag);
    int early;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) early++;
      step();
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_valid_at_L"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, exp);
    step();
    chk({tag, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int sent, got, cyc, stall_bad, order_bad, last_bad, stalls, n;
    logic        held_v, acc, held_l;
    logic [31:0] held_d;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: all-ones kernel, zero bias -> 9.0 at latency 6
    load_all(ONE, 32'd0);
    set_pix(ONE);
    lat6(32'h41100000, "t1");

    // 2: bias 0.5 -> 9.5
    wr(N, 32'h3F000000);
    lat6(32'h41180000, "t2");

    // 3: negative kernel, ReLU per beat
    load_all(M_ONE, 32'd0);
    relu_en = 1'b0;
    lat6(32'hC1100000, "t3_norelu");
    relu_en = 1'b1;
    lat6(32'h00000000, "t3_relu");
    for (int i = 0; i < 4; i++) begin
      relu_en  = (i % 2 == 1);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    relu_en  = 1'b0;
    wait_out(32'hC1100000, "t3_b0");
    wait_out(32'h00000000, "t3_b1");
    wait_out(32'hC1100000, "t3_b2");
    wait_out(32'h00000000, "t3_b3");

    // Out-of-range addresses must not disturb kernel or bias
    wr(N + 1, 32'h40400000);
    wr(63, 32'h40400000);
    lat6(32'hC1100000, "addr_gt_n");

    // 4: 20-beat stream with out_ready toggling every 3 cycles
    load_all(ONE, 32'd0);
    sent = 0; got = 0; cyc = 0;
    stall_bad = 0; order_bad = 0; last_bad = 0; stalls = 0;
    held_v = 1'b0; held_d = '0; held_l = 1'b0;
    while (got < 20 && cyc < 400) begin
      out_ready = ((cyc / 3) % 2 == 0);
      if (out_valid) begin
        if (held_v && (out_data !== held_d || out_last !== held_l)) stall_bad++;
        if (out_ready) begin
          if (out_data !== fp(got + 9)) order_bad++;
          if (out_last !== (got == 19)) last_bad++;
          got++;
          held_v = 1'b0;
        end else begin
          stalls++;
          held_v = 1'b1;
          held_d = out_data;
          held_l = out_last;
        end
      end
      if (sent < 20) begin
        in_valid = 1'b1;
        set_pix(fp(sent + 1));
        in_last  = (sent == 19);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      acc = in_valid & in_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    set_pix(ONE);
    chk("t4_sent", 32'(sent), 32'd20);
    chk("t4_got", 32'(got), 32'd20);
    chk("t4_order", 32'(order_bad), 32'd0);
    chk("t4_last", 32'(last_bad), 32'd0);
    chk("t4_stable", 32'(stall_bad), 32'd0);
    chk("t4_stalled", {31'd0, stalls > 0}, 32'd1);

    // 5: weight write in the acceptance cycle applies only to the next beat
    wt_we    = 1'b1;
    wt_addr  = AW'(4);
    wt_data  = 32'h40000000;
    in_valid = 1'b1;
    step();
    wt_we    = 1'b0;
    step();
    in_valid = 1'b0;
    wait_out(32'h41100000, "t5_old");
    wait_out(32'h41200000, "t5_new");

    // 6: reset with four beats in flight
    wr(4, ONE);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("t6_no_output", 32'(n), 32'd0);
    lat6(32'h00000000, "t6_wt_cleared");
    load_all(ONE, 32'd0);
    lat6(32'h41100000, "t6_reload");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
